// File: rtl/audio_transport_ctrl.sv
// Transport sequencer for the audio recorder/player: codec init, record, play,
// pause and loop-restart over an SRAM split into N_SLOTS slots, plus speed control.
module audio_transport_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int N_SLOTS     = 4,
    parameter int SPEED_W     = 4,
    parameter int MAX_SPEED   = 8,
    parameter int TIMER_SHIFT = 15,
    localparam int SLOT_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_up,
    input  logic               i_down,
    input  logic               i_mode,
    input  logic               i_loop,
    input  logic [SLOT_W-1:0]  i_slot,
    input  logic               i_init_done,
    input  logic [ADDR_W-1:0]  i_rec_addr,
    input  logic               i_rec_done,
    input  logic [ADDR_W-1:0]  i_play_addr,
    input  logic               i_play_done,
    output logic               o_init_start,
    output logic               o_rec_start,
    output logic               o_play_start,
    output logic [ADDR_W-1:0]  o_start_pos,
    output logic [ADDR_W-1:0]  o_end_pos,
    output logic [ADDR_W-1:0]  o_rec_base,
    output logic               o_speed_fast,
    output logic               o_speed_slow,
    output logic [SPEED_W-1:0] o_speed_factor,
    output logic               o_sram_sel,
    output logic [2:0]         o_state,
    output logic [4:0]         o_timer,
    output logic [N_SLOTS-1:0] o_slot_valid
);

    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_RECORD  = 3'd2;
    localparam logic [2:0] ST_PLAY    = 3'd3;
    localparam logic [2:0] ST_PAUSE   = 3'd4;
    localparam logic [2:0] ST_RESTART = 3'd5;

    // A factor of 2^SPEED_W cannot be represented, so clamp to the field's maximum.
    localparam int          FAC_LIM = (MAX_SPEED > (1 << SPEED_W) - 1) ? (1 << SPEED_W) - 1 : MAX_SPEED;
    localparam logic [SPEED_W-1:0] FAC_MAX = SPEED_W'(FAC_LIM);
    localparam logic [SPEED_W-1:0] FAC_ONE = SPEED_W'(1);
    localparam logic [SPEED_W-1:0] FAC_TWO = SPEED_W'(2);
    localparam logic [ADDR_W-1:0]  TIMER_SAT = ADDR_W'(31);

    function automatic logic [ADDR_W-1:0] slot_base(input logic [SLOT_W-1:0] s);
        slot_base = {s, {(ADDR_W-SLOT_W){1'b0}}};
    endfunction

    function automatic logic [ADDR_W-1:0] slot_last(input logic [SLOT_W-1:0] s);
        slot_last = {s, {(ADDR_W-SLOT_W){1'b1}}};
    endfunction

    logic [2:0]         state_r, state_nx_s;
    logic [SLOT_W-1:0]  slot_r, slot_nx_s;
    logic [ADDR_W-1:0]  pos_r, pos_nx_s;
    logic [ADDR_W-1:0]  rec_base_r, base_nx_s;
    logic [ADDR_W-1:0]  start_pos_r, start_pos_nx_s;
    logic [ADDR_W-1:0]  end_pos_r, end_pos_nx_s;
    logic [ADDR_W-1:0]  end_ptr_r [N_SLOTS];
    logic [N_SLOTS-1:0] valid_r, valid_nx_s;
    logic               end_we_s, speed_en_s, speed_clr_s;
    logic               fast_r, fast_nx_s, slow_r, slow_nx_s;
    logic [SPEED_W-1:0] fac_r, fac_nx_s;
    logic [ADDR_W-1:0]  diff_s, tick_s;
    logic [4:0]         timer_r, timer_nx_s;

    // Transport state machine and play-window bookkeeping.
    always_comb begin
        state_nx_s     = state_r;
        slot_nx_s      = slot_r;
        pos_nx_s       = pos_r;
        base_nx_s      = rec_base_r;
        start_pos_nx_s = start_pos_r;
        end_pos_nx_s   = end_pos_r;
        valid_nx_s     = valid_r;
        end_we_s       = 1'b0;
        speed_en_s     = 1'b0;
        speed_clr_s    = 1'b0;
        case (state_r)
            ST_INIT: begin
                if (i_init_done) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                pos_nx_s    = slot_base(i_slot);
                base_nx_s   = slot_base(i_slot);
                speed_clr_s = i_stop;
                if (i_start && !i_mode) begin
                    slot_nx_s  = i_slot;
                    state_nx_s = ST_RECORD;
                end else if (i_start && valid_r[i_slot]) begin
                    slot_nx_s      = i_slot;
                    state_nx_s     = ST_PLAY;
                    start_pos_nx_s = slot_base(i_slot);
                    end_pos_nx_s   = end_ptr_r[i_slot];
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RECORD: begin
                pos_nx_s = i_rec_addr;
                end_we_s = 1'b1;
                if (i_stop || i_rec_done || (i_rec_addr == slot_last(slot_r))) begin
                    state_nx_s         = ST_IDLE;
                    valid_nx_s[slot_r] = (i_rec_addr != slot_base(slot_r));
                end else begin
                    state_nx_s = ST_RECORD;
                end
            end
            ST_PLAY: begin
                pos_nx_s   = i_play_addr;
                speed_en_s = 1'b1;
                if (i_stop) begin
                    state_nx_s = ST_IDLE;
                end else if (i_play_done && i_loop) begin
                    state_nx_s     = ST_RESTART;
                    start_pos_nx_s = slot_base(slot_r);
                    pos_nx_s       = slot_base(slot_r);
                end else if (i_play_done) begin
                    state_nx_s = ST_IDLE;
                end else if (i_start) begin
                    state_nx_s = ST_PAUSE;
                end else begin
                    state_nx_s = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                speed_en_s = 1'b1;
                if (i_stop) begin
                    state_nx_s = ST_IDLE;
                end else if (i_start) begin
                    state_nx_s     = ST_PLAY;
                    start_pos_nx_s = pos_r;
                end else begin
                    state_nx_s = ST_PAUSE;
                end
            end
            ST_RESTART: begin
                state_nx_s = ST_PLAY;
            end
            default: begin
                state_nx_s = ST_INIT;
            end
        endcase
    end

    // Speed direction/factor; slow is the mirror image of fast.
    always_comb begin
        fast_nx_s = fast_r;
        slow_nx_s = slow_r;
        fac_nx_s  = fac_r;
        if (speed_clr_s) begin
            fast_nx_s = 1'b0;
            slow_nx_s = 1'b0;
            fac_nx_s  = FAC_ONE;
        end else if (speed_en_s && (i_up || i_down)) begin
            if (!fast_r && !slow_r) begin
                fast_nx_s = i_up;
                slow_nx_s = !i_up;
                fac_nx_s  = FAC_TWO;
            end else if (fast_r == i_up) begin
                fac_nx_s = (fac_r >= FAC_MAX) ? FAC_MAX : fac_r + FAC_ONE;
            end else if (fac_r <= FAC_TWO) begin
                fast_nx_s = 1'b0;
                slow_nx_s = 1'b0;
                fac_nx_s  = FAC_ONE;
            end else begin
                fac_nx_s = fac_r - FAC_ONE;
            end
        end else begin
            fac_nx_s = fac_r;
        end
    end

    // Elapsed-time ticks relative to the slot base, saturating at 31.
    always_comb begin
        diff_s = pos_nx_s - base_nx_s;
        tick_s = diff_s >> TIMER_SHIFT;
        if (tick_s > TIMER_SAT) begin
            timer_nx_s = 5'd31;
        end else begin
            timer_nx_s = tick_s[4:0];
        end
    end

    // State, outputs and slot table registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= ST_INIT;
            slot_r       <= '0;
            pos_r        <= '0;
            rec_base_r   <= '0;
            start_pos_r  <= '0;
            end_pos_r    <= '0;
            valid_r      <= '0;
            fast_r       <= 1'b0;
            slow_r       <= 1'b0;
            fac_r        <= FAC_ONE;
            timer_r      <= 5'd0;
            o_init_start <= 1'b1;
            o_rec_start  <= 1'b0;
            o_play_start <= 1'b0;
            o_sram_sel   <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                end_ptr_r[i] <= '0;
            end
        end else begin
            state_r      <= state_nx_s;
            slot_r       <= slot_nx_s;
            pos_r        <= pos_nx_s;
            rec_base_r   <= base_nx_s;
            start_pos_r  <= start_pos_nx_s;
            end_pos_r    <= end_pos_nx_s;
            valid_r      <= valid_nx_s;
            fast_r       <= fast_nx_s;
            slow_r       <= slow_nx_s;
            fac_r        <= fac_nx_s;
            timer_r      <= timer_nx_s;
            o_init_start <= (state_nx_s == ST_INIT);
            o_rec_start  <= (state_nx_s == ST_RECORD);
            o_play_start <= (state_nx_s == ST_PLAY);
            o_sram_sel   <= (state_nx_s == ST_PLAY) || (state_nx_s == ST_RESTART);
            if (end_we_s) begin
                end_ptr_r[slot_r] <= i_rec_addr;
            end
        end
    end

    assign o_state        = state_r;
    assign o_start_pos    = start_pos_r;
    assign o_end_pos      = end_pos_r;
    assign o_rec_base     = rec_base_r;
    assign o_speed_fast   = fast_r;
    assign o_speed_slow   = slow_r;
    assign o_speed_factor = fac_r;
    assign o_timer        = timer_r;
    assign o_slot_valid   = valid_r;

endmodule

// File: tb/tb_audio_transport_ctrl.sv
// Directed bench for audio_transport_ctrl: init, record, loop play, pause,
// speed, slot-full, invalid slot and asynchronous reset scenarios.
module tb_audio_transport_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0, i_stop = 1'b0, i_up = 1'b0, i_down = 1'b0;
    logic        i_mode = 1'b0, i_loop = 1'b0;
    logic [1:0]  i_slot = 2'd0;
    logic        i_init_done = 1'b0;
    logic [19:0] i_rec_addr = 20'h0;
    logic        i_rec_done = 1'b0;
    logic [19:0] i_play_addr = 20'h0;
    logic        i_play_done = 1'b0;
    logic        o_init_start, o_rec_start, o_play_start;
    logic [19:0] o_start_pos, o_end_pos, o_rec_base;
    logic        o_speed_fast, o_speed_slow;
    logic [3:0]  o_speed_factor;
    logic        o_sram_sel;
    logic [2:0]  o_state;
    logic [4:0]  o_timer;
    logic [3:0]  o_slot_valid;

    int checks = 0;
    int failures = 0;

    audio_transport_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
        .i_up(i_up), .i_down(i_down), .i_mode(i_mode), .i_loop(i_loop),
        .i_slot(i_slot), .i_init_done(i_init_done), .i_rec_addr(i_rec_addr),
        .i_rec_done(i_rec_done), .i_play_addr(i_play_addr), .i_play_done(i_play_done),
        .o_init_start(o_init_start), .o_rec_start(o_rec_start), .o_play_start(o_play_start),
        .o_start_pos(o_start_pos), .o_end_pos(o_end_pos), .o_rec_base(o_rec_base),
        .o_speed_fast(o_speed_fast), .o_speed_slow(o_speed_slow),
        .o_speed_factor(o_speed_factor), .o_sram_sel(o_sram_sel), .o_state(o_state),
        .o_timer(o_timer), .o_slot_valid(o_slot_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge i_clk);
    endtask

    task automatic pulse_start();
        i_start = 1'b1; @(negedge i_clk); i_start = 1'b0;
    endtask

    task automatic pulse_stop();
        i_stop = 1'b1; @(negedge i_clk); i_stop = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick(3);
        i_rst = 1'b0;
        tick(10);
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        checks++; if (o_init_start !== 1'b1) begin failures++; $display("FAIL reset_init_start got=%b exp=1", o_init_start); end
        checks++; if ({o_rec_start, o_play_start} !== 2'b00) begin failures++; $display("FAIL reset_starts got=%b exp=00", {o_rec_start, o_play_start}); end
        checks++; if (o_slot_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=0000", o_slot_valid); end
        checks++; if ({o_speed_fast, o_speed_slow, o_speed_factor} !== 6'b00_0001) begin failures++; $display("FAIL reset_speed got=%b exp=000001", {o_speed_fast, o_speed_slow, o_speed_factor}); end
        checks++; if ({o_start_pos, o_end_pos, o_timer} !== 45'h0) begin failures++; $display("FAIL reset_pos got=%h exp=0", {o_start_pos, o_end_pos, o_timer}); end
        i_init_done = 1'b1;
        tick(1);
        checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL init_to_idle got=%0d exp=1", o_state); end
        checks++; if (o_init_start !== 1'b0) begin failures++; $display("FAIL init_start_drop got=%b exp=0", o_init_start); end
    endtask

    task automatic test_record();
        i_slot = 2'd2; i_mode = 1'b0; i_rec_addr = 20'h80000;
        pulse_start();
        checks++; if (o_state !== 3'd2 || o_rec_start !== 1'b1) begin failures++; $display("FAIL rec_enter got=%0d/%b exp=2/1", o_state, o_rec_start); end
        checks++; if (o_rec_base !== 20'h80000 || o_sram_sel !== 1'b0) begin failures++; $display("FAIL rec_base got=%h/%b exp=80000/0", o_rec_base, o_sram_sel); end
        for (int k = 1; k <= 4; k++) begin
            i_rec_addr = 20'h80000 + 20'(k * 64);
            tick(1);
        end
        checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL rec_hold got=%0d exp=2", o_state); end
        pulse_stop();
        checks++; if (o_state !== 3'd1 || o_rec_start !== 1'b0) begin failures++; $display("FAIL rec_exit got=%0d/%b exp=1/0", o_state, o_rec_start); end
        checks++; if (o_slot_valid !== 4'b0100) begin failures++; $display("FAIL rec_valid got=%b exp=0100", o_slot_valid); end
    endtask

    task automatic test_play_loop();
        i_mode = 1'b1; i_loop = 1'b1; i_slot = 2'd2; i_play_addr = 20'h80000;
        pulse_start();
        checks++; if (o_state !== 3'd3 || o_play_start !== 1'b1 || o_sram_sel !== 1'b1) begin failures++; $display("FAIL play_enter got=%0d/%b/%b exp=3/1/1", o_state, o_play_start, o_sram_sel); end
        checks++; if (o_start_pos !== 20'h80000 || o_end_pos !== 20'h80100) begin failures++; $display("FAIL play_window got=%h-%h exp=80000-80100", o_start_pos, o_end_pos); end
        i_play_addr = 20'h98000;
        tick(1);
        checks++; if (o_timer !== 5'd3) begin failures++; $display("FAIL timer got=%0d exp=3", o_timer); end
        i_play_done = 1'b1; @(negedge i_clk); i_play_done = 1'b0;
        checks++; if (o_state !== 3'd5 || o_play_start !== 1'b0 || o_sram_sel !== 1'b1) begin failures++; $display("FAIL restart got=%0d/%b/%b exp=5/0/1", o_state, o_play_start, o_sram_sel); end
        tick(1);
        checks++; if (o_state !== 3'd3 || o_play_start !== 1'b1) begin failures++; $display("FAIL restart_play got=%0d/%b exp=3/1", o_state, o_play_start); end
        checks++; if (o_start_pos !== 20'h80000 || o_end_pos !== 20'h80100) begin failures++; $display("FAIL restart_window got=%h-%h exp=80000-80100", o_start_pos, o_end_pos); end
    endtask

    task automatic test_pause();
        i_play_addr = 20'h80040;
        pulse_start();
        checks++; if (o_state !== 3'd4 || o_play_start !== 1'b0) begin failures++; $display("FAIL pause_enter got=%0d/%b exp=4/0", o_state, o_play_start); end
        i_play_addr = 20'h80080;
        tick(2);
        pulse_start();
        checks++; if (o_state !== 3'd3 || o_play_start !== 1'b1) begin failures++; $display("FAIL resume got=%0d/%b exp=3/1", o_state, o_play_start); end
        checks++; if (o_start_pos !== 20'h80040) begin failures++; $display("FAIL resume_pos got=%h exp=80040", o_start_pos); end
    endtask

    task automatic test_speed();
        for (int k = 0; k < 9; k++) begin
            i_up = 1'b1; @(negedge i_clk); i_up = 1'b0; @(negedge i_clk);
            if (k == 0) begin
                checks++; if ({o_speed_fast, o_speed_slow, o_speed_factor} !== 6'b10_0010) begin failures++; $display("FAIL speed_first_up got=%b exp=100010", {o_speed_fast, o_speed_slow, o_speed_factor}); end
            end
        end
        checks++; if ({o_speed_fast, o_speed_slow, o_speed_factor} !== 6'b10_1000) begin failures++; $display("FAIL speed_sat got=%b exp=101000", {o_speed_fast, o_speed_slow, o_speed_factor}); end
        for (int k = 0; k < 7; k++) begin
            i_down = 1'b1; @(negedge i_clk); i_down = 1'b0; @(negedge i_clk);
        end
        checks++; if ({o_speed_fast, o_speed_slow, o_speed_factor} !== 6'b00_0001) begin failures++; $display("FAIL speed_normal got=%b exp=000001", {o_speed_fast, o_speed_slow, o_speed_factor}); end
        i_down = 1'b1; @(negedge i_clk); i_down = 1'b0;
        checks++; if ({o_speed_fast, o_speed_slow, o_speed_factor} !== 6'b01_0010) begin failures++; $display("FAIL speed_slow got=%b exp=010010", {o_speed_fast, o_speed_slow, o_speed_factor}); end
        i_up = 1'b1; i_down = 1'b1; @(negedge i_clk); i_up = 1'b0; i_down = 1'b0;
        checks++; if ({o_speed_fast, o_speed_slow, o_speed_factor} !== 6'b00_0001) begin failures++; $display("FAIL speed_up_prio got=%b exp=000001", {o_speed_fast, o_speed_slow, o_speed_factor}); end
        i_up = 1'b1; @(negedge i_clk); i_up = 1'b0;
        pulse_stop();
        checks++; if (o_state !== 3'd1 || {o_speed_fast, o_speed_factor} !== 5'b1_0010) begin failures++; $display("FAIL speed_persist got=%0d/%b exp=1/10010", o_state, {o_speed_fast, o_speed_factor}); end
        pulse_stop();
        checks++; if ({o_speed_fast, o_speed_slow, o_speed_factor} !== 6'b00_0001) begin failures++; $display("FAIL speed_idle_stop got=%b exp=000001", {o_speed_fast, o_speed_slow, o_speed_factor}); end
    endtask

    task automatic test_edges();
        i_slot = 2'd0; i_mode = 1'b1;
        pulse_start();
        checks++; if (o_state !== 3'd1 || o_play_start !== 1'b0) begin failures++; $display("FAIL invalid_slot got=%0d/%b exp=1/0", o_state, o_play_start); end
        i_mode = 1'b0; i_rec_addr = 20'h00000;
        pulse_start();
        i_rec_addr = 20'h3FFFE;
        tick(1);
        checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL full_before got=%0d exp=2", o_state); end
        i_rec_addr = 20'h3FFFF;
        tick(1);
        checks++; if (o_state !== 3'd1 || o_slot_valid !== 4'b0101) begin failures++; $display("FAIL slot_full got=%0d/%b exp=1/0101", o_state, o_slot_valid); end
        i_mode = 1'b1; i_loop = 1'b0;
        pulse_start();
        checks++; if (o_state !== 3'd3 || o_start_pos !== 20'h00000 || o_end_pos !== 20'h3FFFF) begin failures++; $display("FAIL play_slot0 got=%0d %h-%h exp=3 00000-3ffff", o_state, o_start_pos, o_end_pos); end
        i_play_done = 1'b1; @(negedge i_clk); i_play_done = 1'b0;
        checks++; if (o_state !== 3'd1 || o_play_start !== 1'b0) begin failures++; $display("FAIL done_noloop got=%0d/%b exp=1/0", o_state, o_play_start); end
        i_slot = 2'd2; i_mode = 1'b0; i_rec_addr = 20'h80000;
        pulse_start();
        i_rec_done = 1'b1; @(negedge i_clk); i_rec_done = 1'b0;
        checks++; if (o_state !== 3'd1 || o_slot_valid !== 4'b0001) begin failures++; $display("FAIL empty_rec got=%0d/%b exp=1/0001", o_state, o_slot_valid); end
    endtask

    task automatic test_async_reset();
        i_slot = 2'd0; i_mode = 1'b1;
        pulse_start();
        checks++; if (o_state !== 3'd3) begin failures++; $display("FAIL pre_rst_play got=%0d exp=3", o_state); end
        i_rst = 1'b1;
        #1;
        checks++; if (o_state !== 3'd0 || o_init_start !== 1'b1 || o_play_start !== 1'b0) begin failures++; $display("FAIL async_rst got=%0d/%b/%b exp=0/1/0", o_state, o_init_start, o_play_start); end
        checks++; if (o_slot_valid !== 4'b0000 || o_start_pos !== 20'h0 || o_end_pos !== 20'h0) begin failures++; $display("FAIL async_rst_flags got=%b %h %h exp=0000 0 0", o_slot_valid, o_start_pos, o_end_pos); end
        @(negedge i_clk);
        i_rst = 1'b0;
        tick(2);
        i_slot = 2'd0;
        pulse_start();
        checks++; if (o_state !== 3'd1) begin failures++; $display("FAIL post_rst_invalid got=%0d exp=1", o_state); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_record();
        test_play_loop();
        test_pause();
        test_speed();
        test_edges();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_transport_ctrl.md
# audio_transport_ctrl

Parametrised transport controller for the audio recorder/player. It sequences codec init, record, play, pause and stop over a partitioned SRAM. Memory is divided into N_SLOTS independent recording slots, each with its own stored end pointer. The block adds loop playback and a parametrised fast/slow speed range. It sits between the debounced key/switch inputs and the I2C-init, recorder and player engines, and drives their start levels and play window.

## Interface
- ADDR_W, 20: SRAM word-address width.
- N_SLOTS, 4: number of slots; power of two, 1..16. SLOT_W = max(1, clog2(N_SLOTS)).
- SPEED_W, 4: width of the speed-factor field.
- MAX_SPEED, 8: largest speed factor; 2 ≤ MAX_SPEED ≤ 2^SPEED_W.
- TIMER_SHIFT, 15: log2 of samples per timer tick.
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start, i_stop, i_up, i_down  in  1 each  single-cycle key pulses, already debounced.
- i_mode  in  1  0 = record, 1 = play; sampled on start in IDLE.
- i_loop  in  1  1 = restart playback at slot base on play done; sampled live.
- i_slot  in  SLOT_W  slot select; sampled on start in IDLE.
- i_init_done  in  1  I2C init finished (level).
- i_rec_addr  in  ADDR_W  recorder's current absolute write address.
- i_rec_done  in  1  recorder finished pulse.
- i_play_addr  in  ADDR_W  player's current absolute read address.
- i_play_done  in  1  player reached end pulse.
- o_init_start, o_rec_start, o_play_start  out  1 each  engine enable levels.
- o_start_pos, o_end_pos  out  ADDR_W each  play window, absolute addresses.
- o_rec_base  out  ADDR_W  base address of the active slot.
- o_speed_fast, o_speed_slow  out  1 each  speed direction; both 0 = normal.
- o_speed_factor  out  SPEED_W  current factor, 1..MAX_SPEED.
- o_sram_sel  out  1  1 = player owns the SRAM address bus (PLAY/RESTART), 0 = recorder.
- o_state  out  3  INIT=0, IDLE=1, RECORD=2, PLAY=3, PAUSE=4, RESTART=5.
- o_timer  out  5  (pos − base) >> TIMER_SHIFT, saturating at 31.
- o_slot_valid  out  N_SLOTS  per-slot "holds a recording" flags.

## Operation
- Reset values:
  - State INIT; o_init_start = 1; all other start levels 0.
  - Positions 0; speed normal with factor 1; o_slot_valid all 0; all slot end pointers 0; o_timer 0.
- Slot base = slot << (ADDR_W − SLOT_W). Slot last address = base + 2^(ADDR_W − SLOT_W) − 1.
- INIT: hold o_init_start = 1. When i_init_done = 1, drop it and go to IDLE.
- IDLE: all start levels 0; pos = base of i_slot. On i_start:
  - i_mode = 0: latch slot, go to RECORD.
  - i_mode = 1 with slot valid: latch slot, go to PLAY with start = base and end = that slot's end pointer.
  - i_mode = 1 with slot invalid: ignore the start; stay in IDLE.
  - i_stop in IDLE resets speed to normal with factor 1.
- RECORD: o_rec_start = 1; pos tracks i_rec_addr; end[slot] tracks i_rec_addr. Exit to IDLE and set valid[slot] on any of:
  - i_stop,
  - i_rec_done,
  - i_rec_addr = slot last address (slot full).
  - Exception: if i_rec_addr = base at exit, valid[slot] is cleared instead.
- PLAY: o_play_start = 1; pos tracks i_play_addr. Event priority: i_stop, then i_play_done, then i_start.
  - i_stop: go to IDLE.
  - i_play_done with i_loop = 1: go to RESTART.
  - i_play_done with i_loop = 0: go to IDLE.
  - i_start: go to PAUSE.
- PAUSE: o_play_start = 0; pos frozen.
  - i_stop: go to IDLE.
  - i_start: go to PLAY with o_start_pos = frozen pos.
- RESTART: o_play_start = 0 for exactly one cycle; o_start_pos = base. Then go to PLAY.
- Speed, updated in PLAY and PAUSE only; i_up has priority over i_down if both pulse in the same cycle:
  - Normal + up: fast, factor 2. Normal + down: slow, factor 2.
  - Fast + up: factor + 1, saturating at MAX_SPEED.
  - Fast + down: factor − 1; reaching 1 → normal.
  - Slow: mirror image of fast (down increases the factor, up decreases it).
- Speed state persists across plays.

## Timing
- All outputs are registered. A state change and its start-level change appear on the clock edge after the triggering pulse; latency 1 cycle.
- o_start_pos and o_end_pos are stable from the cycle o_play_start rises until it falls.
- The end-pointer write in RECORD happens in the same cycle as the exit transition.
- Asynchronous i_rst mid-operation aborts immediately to reset values and clears all slot flags and end pointers.

## Test plan
- Init: hold i_init_done = 0 for 10 cycles → state INIT, o_init_start = 1. Raise i_init_done → IDLE next cycle, o_init_start = 0.
- Record slot 2 (N_SLOTS = 4): i_rec_addr ramps 0x80000 to 0x80100, then i_stop → end[2] = 0x80100, o_slot_valid = 4'b0100, state IDLE.
- Play slot 2 with i_loop = 1: pulse i_play_done → exactly one RESTART cycle with o_play_start = 0, then PLAY with o_start_pos = 0x80000 and o_end_pos = 0x80100.
- Pause/resume: in PLAY at i_play_addr = 0x80040, pulse i_start → PAUSE. Pulse i_start again → PLAY with o_start_pos = 0x80040.
- Speed: from normal, 9 × i_up → fast with factor 8 (saturated). Then 7 × i_down → normal, factor 1. One more i_down → slow, factor 2.
- Edge cases:
  - Play on invalid slot 0 → stays IDLE.
  - Record until i_rec_addr = 0x3FFFF in slot 0 → auto-exit to IDLE.
  - Assert i_rst during PLAY → INIT, all flags 0.
